// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one fetch at a time to instruction memory,
// presents the returned word to decode and handles branch/trap redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap_valid,
    input  logic [31:0] trap_vector,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        redir_s;
    logic [31:0] target_s;

    // Trap outranks branch; targets are forced to word alignment.
    assign redir_s  = trap_valid | redirect_valid;
    assign target_s = (trap_valid ? trap_vector : redirect_target) & 32'hFFFF_FFFC;

    // Next-state, PC and instruction-capture logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        case (state_q)
            S_IDLE: begin
                if (redir_s) begin
                    pc_d    = target_s;
                    state_d = S_REQ;
                end else if (!stall) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (redir_s) begin
                    pc_d    = target_s;
                    state_d = imem_gnt ? S_DRAIN : S_REQ;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (redir_s) begin
                    pc_d    = target_s;
                    state_d = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    inst_data_d = imem_rdata;
                    inst_pc_d   = pc_q;
                    pc_d        = pc_q + 32'd4;
                    state_d     = S_OUT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                // The in-flight response belongs to a squashed PC and is dropped.
                if (redir_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                state_d = imem_rvalid ? S_REQ : S_DRAIN;
            end
            S_OUT: begin
                if (redir_s) begin
                    pc_d    = target_s;
                    state_d = S_REQ;
                end else if (!stall) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_VECTOR;
            inst_data_q <= 32'h0000_0000;
            inst_pc_q   <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == S_OUT);
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a directed vector sequence followed by random
// traffic checked against a transaction-level reference model.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .pc              (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rd;
        logic [31:0] rtgt;
        logic        trp;
        logic [31:0] tvec;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_data;
        logic [31:0] e_ipc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [23];

    // Reference model: fetch progress as flags rather than an FSM encoding.
    logic        m_idle, m_outstanding, m_drop, m_hold;
    logic [31:0] m_pc, m_data, m_ipc;

    function automatic vec_t mk(input logic rst, input logic stl, input logic rd,
                                input logic [31:0] rtgt, input logic trp,
                                input logic [31:0] tvec, input logic gnt, input logic rv,
                                input logic [31:0] rdata, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_data, input logic [31:0] e_ipc,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rd = rd; v.rtgt = rtgt; v.trp = trp; v.tvec = tvec;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_data = e_data; v.e_ipc = e_ipc; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic rd,
                         input logic [31:0] rtgt, input logic trp, input logic [31:0] tvec,
                         input logic gnt, input logic rv, input logic [31:0] rdata);
        reset = rst; stall = stl; redirect_valid = rd; redirect_target = rtgt;
        trap_valid = trp; trap_vector = tvec; imem_gnt = gnt; imem_rvalid = rv;
        imem_rdata = rdata;
    endtask

    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        redir = trap_valid | redirect_valid;
        tgt   = trap_valid ? {trap_vector[31:2], 2'b00} : {redirect_target[31:2], 2'b00};
        if (reset) begin
            m_idle = 1'b1; m_outstanding = 1'b0; m_drop = 1'b0; m_hold = 1'b0;
            m_pc = 32'h0000_0000; m_data = 32'h0000_0000; m_ipc = 32'h0000_0000;
        end else if (m_idle) begin
            if (redir) m_pc = tgt;
            if (redir || !stall) m_idle = 1'b0;
        end else if (m_hold) begin
            if (redir) m_pc = tgt;
            if (redir || !stall) m_hold = 1'b0;
        end else if (!m_outstanding) begin
            if (imem_gnt) begin
                m_outstanding = 1'b1;
                m_drop = redir;
            end
            if (redir) m_pc = tgt;
        end else if (imem_rvalid) begin
            m_outstanding = 1'b0;
            if (!m_drop && !redir) begin
                m_data = imem_rdata;
                m_ipc  = m_pc;
                m_pc   = m_pc + 32'd4;
                m_hold = 1'b1;
            end
            if (redir) m_pc = tgt;
        end else if (redir) begin
            m_drop = 1'b1;
            m_pc = tgt;
        end
    endtask

    initial begin
        tbl[0]  = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h0,1'b0,32'h0,32'h0,32'h0);
        tbl[1]  = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0,1'b0,32'h0,32'h0,32'h0);
        tbl[2]  = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h13,         1'b0,32'h0,1'b0,32'h0,32'h0,32'h0);
        tbl[3]  = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h0,1'b1,32'h13,32'h0,32'h4);
        tbl[4]  = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h0,1'b1,32'h13,32'h0,32'h4);
        tbl[5]  = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h0,1'b1,32'h13,32'h0,32'h4);
        tbl[6]  = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h0,1'b1,32'h13,32'h0,32'h4);
        tbl[7]  = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h4,1'b0,32'h13,32'h0,32'h4);
        tbl[8]  = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h4,1'b0,32'h13,32'h0,32'h4);
        tbl[9]  = mk(1'b0,1'b0,1'b1,32'h102,1'b0,32'h0,1'b0,1'b0,32'h0,        1'b0,32'h0,1'b0,32'h13,32'h0,32'h4);
        tbl[10] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'hDEAD_BEEF,  1'b0,32'h0,1'b0,32'h13,32'h0,32'h100);
        tbl[11] = mk(1'b0,1'b0,1'b1,32'h200,1'b1,32'h8000_0000,1'b0,1'b0,32'h0,1'b1,32'h100,1'b0,32'h13,32'h0,32'h100);
        tbl[12] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h8000_0000,1'b0,32'h13,32'h0,32'h8000_0000);
        tbl[13] = mk(1'b0,1'b0,1'b1,32'hFFFF_FFFE,1'b0,32'h0,1'b1,1'b0,32'h0,  1'b1,32'h8000_0000,1'b0,32'h13,32'h0,32'h8000_0000);
        tbl[14] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h0000_0BAD,  1'b0,32'h0,1'b0,32'h13,32'h0,32'hFFFF_FFFC);
        tbl[15] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'hFFFF_FFFC,1'b0,32'h13,32'h0,32'hFFFF_FFFC);
        tbl[16] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h1234_5678,  1'b0,32'h0,1'b0,32'h13,32'h0,32'hFFFF_FFFC);
        tbl[17] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h0,1'b1,32'h1234_5678,32'hFFFF_FFFC,32'h0);
        tbl[18] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0,1'b0,32'h1234_5678,32'hFFFF_FFFC,32'h0);
        tbl[19] = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h0,1'b0,32'h1234_5678,32'hFFFF_FFFC,32'h0);
        tbl[20] = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h77,         1'b0,32'h0,1'b0,32'h0,32'h0,32'h0);
        tbl[21] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h0,1'b0,32'h0,32'h0,32'h0);
        tbl[22] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h0,1'b0,32'h0,32'h0,32'h0);

        drive(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0);
        repeat (2) @(posedge clk);

        // Directed sequence: each row's outputs are those seen while its inputs are applied.
        for (int i = 0; i < 23; i++) begin
            #1;
            drive(tbl[i].rst, tbl[i].stl, tbl[i].rd, tbl[i].rtgt, tbl[i].trp, tbl[i].tvec,
                  tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            check($sformatf("vec%0d imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
            if (tbl[i].e_req) check($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("vec%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_valid});
            check($sformatf("vec%0d inst_data", i), inst_data, tbl[i].e_data);
            check($sformatf("vec%0d inst_pc", i), inst_pc, tbl[i].e_pc == tbl[i].e_pc ? tbl[i].e_ipc : 32'h0);
            check($sformatf("vec%0d pc", i), pc, tbl[i].e_pc);
            @(posedge clk);
        end

        // Random traffic against the reference model, starting from reset.
        #1;
        drive(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0);
        model_step();
        @(posedge clk);
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] rt, tv;
            #1;
            rt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            tv = $urandom;
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0), rt, ($urandom_range(0, 24) == 0), tv,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            check("rnd imem_req", {31'd0, imem_req},
                  {31'd0, (!m_idle && !m_outstanding && !m_hold)});
            if (!m_idle && !m_outstanding && !m_hold) check("rnd imem_addr", imem_addr, m_pc);
            check("rnd inst_valid", {31'd0, inst_valid}, {31'd0, m_hold});
            check("rnd inst_data", inst_data, m_data);
            check("rnd inst_pc", inst_pc, m_ipc);
            check("rnd pc", pc, m_pc);
            model_step();
            @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL set the PC value loaded at reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 stall  input  1  SHALL hold the presented instruction and block new requests while high.
REQ-005 redirect_valid  input  1  SHALL request a branch/jump to redirect_target.
REQ-006 redirect_target  input  32  SHALL give the branch/jump target PC.
REQ-007 trap_valid  input  1  SHALL request a redirect to trap_vector.
REQ-008 trap_vector  input  32  SHALL give the trap handler PC.
REQ-009 imem_req  output  1  SHALL indicate a valid fetch request.
REQ-010 imem_addr  output  32  SHALL carry the fetch address, equal to pc while imem_req=1.
REQ-011 imem_gnt  input  1  SHALL indicate memory accepted the request this cycle.
REQ-012 imem_rvalid  input  1  SHALL indicate imem_rdata is valid for the oldest accepted request.
REQ-013 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-014 inst_valid  output  1  SHALL indicate inst_data/inst_pc are valid for decode.
REQ-015 inst_data  output  32  SHALL hold the fetched instruction.
REQ-016 inst_pc  output  32  SHALL hold the address of inst_data.
REQ-017 pc  output  32  SHALL expose the current PC register.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DRAIN, OUT; at most one request outstanding.
REQ-019 IDLE: outputs inactive; -> REQ when stall=0, else stay.
REQ-020 REQ: imem_req=1, imem_addr=pc; imem_gnt=1 -> WAIT; request and address held stable until granted unless redirected.
REQ-021 WAIT: imem_rvalid=1 -> capture inst_data=imem_rdata, inst_pc=pc, pc<=pc+4, -> OUT (inst_valid=1 from next cycle, latency 1 cycle after rvalid).
REQ-022 OUT: inst_valid=1; stall=1 -> stay, outputs frozen; stall=0 -> REQ next cycle, inst_valid=0.
REQ-023 DRAIN: wait for imem_rvalid, discard data, -> REQ.
REQ-024 Redirect = trap_valid or redirect_valid; trap_valid SHALL win when both high; effective target SHALL have bits [1:0] cleared.
REQ-025 Redirect in IDLE/REQ (no gnt): pc<=target, -> REQ; ungranted request address changes next cycle.
REQ-026 Redirect in REQ with imem_gnt=1, or in WAIT without imem_rvalid: pc<=target, -> DRAIN.
REQ-027 Redirect in WAIT with imem_rvalid=1: response discarded, inst_valid stays 0, pc<=target, -> REQ.
REQ-028 Redirect in OUT: inst_valid<=0 next cycle, pc<=target, -> REQ regardless of stall.
REQ-029 Redirect in DRAIN: pc<=target, remain DRAIN until rvalid.
REQ-030 stall SHALL NOT cancel a granted request; stall has no effect in REQ, WAIT, DRAIN.
REQ-031 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-032 imem_rvalid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-033 reset=1 SHALL, on the clock edge, set state IDLE, pc=RESET_VECTOR, imem_req=0, inst_valid=0, inst_data=0, inst_pc=0, overriding all other inputs.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request; a later stray imem_rvalid SHALL be ignored (REQ-032).

Verification
REQ-035 Reset, stall=0, gnt same cycle, rvalid 1 cycle later with 32'h0000_0013 -> imem_addr=0, inst_valid=1 with inst_pc=0, inst_data=32'h13, next imem_addr=4.
REQ-036 Hold stall=1 for 3 cycles in OUT -> inst_valid, inst_data, inst_pc unchanged, imem_req=0; release -> imem_req=1 next cycle.
REQ-037 redirect_valid with target 32'h0000_0102 in WAIT before rvalid -> DRAIN, returned word discarded, next imem_addr=32'h0000_0100, inst_valid never pulses for old PC.
REQ-038 trap_valid (vector 32'h8000_0000) and redirect_valid (32'h200) same cycle in REQ -> imem_addr=32'h8000_0000.
REQ-039 pc=32'hFFFF_FFFC fetch completes -> pc=32'h0000_0000.
REQ-040 reset asserted in WAIT, then stray imem_rvalid -> pc=RESET_VECTOR, inst_valid=0, fresh request to RESET_VECTOR.
